// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction-fetch stage: PC, IM address, IF/ID register, halt handling.
// Optional fetch/bubble performance counters are enabled with IF_PERF_CNT_EN.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IM_AW    = 8,
  parameter logic [5:0]  HALT_OP  = 6'b111111
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  output logic [IM_AW-1:0] im_addr,
  input  logic [31:0]      im_instr,
  output logic [31:0]      cur_pc,
  output logic             ifid_valid,
  output logic [31:0]      ifid_instr,
  output logic [31:0]      ifid_pc,
  output logic [31:0]      ifid_pc4,
  output logic             halted
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]      fetch_cnt,
  output logic [31:0]      bubble_cnt
`endif
);

  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n, pc_plus4;
  logic        valid_n;
  logic [31:0] instr_n, ipc_n, ipc4_n;

  assign pc_plus4 = pc + 32'd4;
  assign im_addr  = pc[IM_AW+1:2];
  assign cur_pc   = pc;
  assign halted   = (state == S_HALT);

  always_comb begin
    state_n = state;
    pc_n    = pc;
    valid_n = ifid_valid;
    instr_n = ifid_instr;
    ipc_n   = ifid_pc;
    ipc4_n  = ifid_pc4;
    if (redirect) begin
      // Redirect wins over stall and also leaves HALT (halt fetched on a wrong path).
      state_n = S_RUN;
      pc_n    = redirect_pc & ~32'h3;
      valid_n = 1'b0;
      instr_n = 32'h0;
      ipc_n   = 32'h0;
      ipc4_n  = 32'h0;
    end else if (!stall) begin
      if (state == S_RUN) begin
        valid_n = 1'b1;
        instr_n = im_instr;
        ipc_n   = pc;
        ipc4_n  = pc_plus4;
        if (im_instr[31:26] == HALT_OP) begin
          state_n = S_HALT;
        end else begin
          pc_n = pc_plus4;
        end
      end else begin
        valid_n = 1'b0;
        instr_n = 32'h0;
        ipc_n   = 32'h0;
        ipc4_n  = 32'h0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_RUN;
      pc         <= RESET_PC;
      ifid_valid <= 1'b0;
      ifid_instr <= 32'h0;
      ifid_pc    <= 32'h0;
      ifid_pc4   <= 32'h0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      ifid_valid <= valid_n;
      ifid_instr <= instr_n;
      ifid_pc    <= ipc_n;
      ifid_pc4   <= ipc4_n;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic fetch_evt, bubble_evt;

  assign fetch_evt  = !redirect && !stall && (state == S_RUN);
  assign bubble_evt = redirect || (!stall && (state == S_HALT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt  <= 32'h0;
      bubble_cnt <= 32'h0;
    end else begin
      if (fetch_evt)  fetch_cnt  <= fetch_cnt + 32'd1;
      if (bubble_evt) bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage (directed scenarios plus randomized run vs reference model).
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n, stall, redirect;
  logic [31:0] redirect_pc;
  logic [7:0]  im_addr;
  logic [31:0] im_instr, cur_pc, ifid_instr, ifid_pc, ifid_pc4;
  logic        ifid_valid, halted;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt, bubble_cnt;
`endif

  logic [31:0] mem [256];
  assign im_instr = mem[im_addr];

  int errors = 0;
  int checks = 0;

  // Reference model state: architectural view of the fetch stage.
  logic [31:0] m_pc, m_instr, m_ipc, m_fc, m_bc;
  logic        m_valid, m_halt;

  if_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .im_addr(im_addr), .im_instr(im_instr), .cur_pc(cur_pc), .ifid_valid(ifid_valid),
    .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4), .halted(halted)
`ifdef IF_PERF_CNT_EN
    , .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0; m_valid = 1'b0; m_halt = 1'b0;
    m_fc = 32'h0; m_bc = 32'h0;
  endtask

  task automatic model_edge();
    logic [31:0] w;
    w = mem[(m_pc / 4) % 256];
    if (redirect) begin
      m_pc = redirect_pc - (redirect_pc % 4);
      m_halt = 1'b0; m_valid = 1'b0; m_instr = 32'h0; m_bc = m_bc + 1;
    end else if (stall) begin
      m_pc = m_pc;
    end else if (!m_halt) begin
      m_valid = 1'b1; m_instr = w; m_ipc = m_pc; m_fc = m_fc + 1;
      if ((w >> 26) == 32'd63) m_halt = 1'b1;
      else m_pc = m_pc + 32'd4;
    end else begin
      m_valid = 1'b0; m_instr = 32'h0; m_bc = m_bc + 1;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0100_0000 | i;
    for (int i = 0; i < 4; i++) mem[i] = 32'h1111_1111 * (i + 1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    tick(); tick();
    rst_n = 1'b0;
    #1;
    checks++; if (cur_pc !== 32'h0) begin errors++; $display("FAIL reset_curpc got=%h exp=%h", cur_pc, 32'h0); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", ifid_valid); end
    checks++; if (ifid_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h exp=0", ifid_instr); end
    checks++; if (ifid_pc !== 32'h0 || ifid_pc4 !== 32'h0) begin errors++; $display("FAIL reset_pcs got=%h/%h exp=0/0", ifid_pc, ifid_pc4); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b exp=0", halted); end
`ifdef IF_PERF_CNT_EN
    checks++; if (fetch_cnt !== 32'h0 || bubble_cnt !== 32'h0) begin errors++; $display("FAIL reset_cnts got=%0d/%0d exp=0/0", fetch_cnt, bubble_cnt); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (ifid_instr !== 32'h1111_1111 * (k + 1) || ifid_valid !== 1'b1) begin
        errors++; $display("FAIL seq_instr%0d got=%h v=%b exp=%h v=1", k, ifid_instr, ifid_valid, 32'h1111_1111 * (k + 1)); end
      checks++; if (ifid_pc !== 32'(4 * k) || ifid_pc4 !== 32'(4 * k + 4)) begin
        errors++; $display("FAIL seq_pc%0d got=%h/%h exp=%h/%h", k, ifid_pc, ifid_pc4, 4 * k, 4 * k + 4); end
    end
    checks++; if (cur_pc !== 32'h10) begin errors++; $display("FAIL seq_curpc got=%h exp=10", cur_pc); end
  endtask

  task automatic test_stall();
    apply_reset();
    tick(); tick();
    stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (cur_pc !== 32'h8) begin errors++; $display("FAIL stall_curpc%0d got=%h exp=8", k, cur_pc); end
      checks++; if (ifid_instr !== 32'h2222_2222 || ifid_pc !== 32'h4) begin
        errors++; $display("FAIL stall_hold%0d got=%h@%h exp=22222222@4", k, ifid_instr, ifid_pc); end
    end
    stall = 1'b0;
    tick();
    checks++; if (ifid_pc !== 32'h8 || ifid_instr !== 32'h3333_3333 || cur_pc !== 32'hC) begin
      errors++; $display("FAIL stall_release got=%h@%h pc=%h exp=33333333@8 pc=c", ifid_instr, ifid_pc, cur_pc); end
  endtask

  task automatic test_redirect_over_stall();
    apply_reset();
    tick();
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h47;
    tick();
    checks++; if (cur_pc !== 32'h44) begin errors++; $display("FAIL redir_curpc got=%h exp=44", cur_pc); end
    checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin
      errors++; $display("FAIL redir_bubble got=v%b %h exp=v0 0", ifid_valid, ifid_instr); end
    stall = 1'b0; redirect = 1'b0;
    tick();
    checks++; if (ifid_pc !== 32'h44 || ifid_valid !== 1'b1 || ifid_instr !== mem[8'h11]) begin
      errors++; $display("FAIL redir_fetch got=%h@%h v=%b exp=%h@44 v=1", ifid_instr, ifid_pc, ifid_valid, mem[8'h11]); end
  endtask

  task automatic test_halt();
    apply_reset();
    mem[4] = 32'hFC00_0000;
    for (int k = 0; k < 5; k++) tick();
    checks++; if (ifid_instr !== 32'hFC00_0000 || ifid_valid !== 1'b1 || halted !== 1'b1 || cur_pc !== 32'h10) begin
      errors++; $display("FAIL halt_latch got=%h v=%b h=%b pc=%h exp=fc000000 v=1 h=1 pc=10", ifid_instr, ifid_valid, halted, cur_pc); end
    stall = 1'b1;
    tick();
    checks++; if (ifid_instr !== 32'hFC00_0000 || ifid_valid !== 1'b1) begin
      errors++; $display("FAIL halt_stall got=%h v=%b exp=fc000000 v=1", ifid_instr, ifid_valid); end
    stall = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (ifid_valid !== 1'b0 || halted !== 1'b1 || cur_pc !== 32'h10) begin
        errors++; $display("FAIL halt_bubble%0d got=v%b h=%b pc=%h exp=v0 h1 pc=10", k, ifid_valid, halted, cur_pc); end
    end
    redirect = 1'b1; redirect_pc = 32'h20;
    tick();
    redirect = 1'b0;
    checks++; if (halted !== 1'b0 || cur_pc !== 32'h20 || ifid_valid !== 1'b0) begin
      errors++; $display("FAIL halt_exit got=h%b pc=%h v=%b exp=h0 pc=20 v0", halted, cur_pc, ifid_valid); end
    tick();
    checks++; if (ifid_pc !== 32'h20 || ifid_valid !== 1'b1 || ifid_instr !== mem[8]) begin
      errors++; $display("FAIL halt_resume got=%h@%h v=%b exp=%h@20 v=1", ifid_instr, ifid_pc, ifid_valid, mem[8]); end
  endtask

  task automatic test_wrap_and_async_reset();
    apply_reset();
    mem[8'hFF] = 32'h1234_5678;
    redirect = 1'b1; redirect_pc = 32'h3FC;
    tick();
    redirect = 1'b0;
    checks++; if (cur_pc !== 32'h3FC || im_addr !== 8'hFF) begin
      errors++; $display("FAIL wrap_pre got=pc%h a%h exp=pc3fc aff", cur_pc, im_addr); end
    tick();
    checks++; if (cur_pc !== 32'h400 || im_addr !== 8'h00) begin
      errors++; $display("FAIL wrap_post got=pc%h a%h exp=pc400 a00", cur_pc, im_addr); end
    checks++; if (ifid_instr !== 32'h1234_5678 || ifid_pc !== 32'h3FC || ifid_pc4 !== 32'h400) begin
      errors++; $display("FAIL wrap_ifid got=%h@%h/%h exp=12345678@3fc/400", ifid_instr, ifid_pc, ifid_pc4); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (cur_pc !== 32'h0 || ifid_valid !== 1'b0 || ifid_instr !== 32'h0 || ifid_pc !== 32'h0 || ifid_pc4 !== 32'h0 || halted !== 1'b0) begin
      errors++; $display("FAIL async_reset got=pc%h v%b %h %h %h h%b exp=all 0", cur_pc, ifid_valid, ifid_instr, ifid_pc, ifid_pc4, halted); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef IF_PERF_CNT_EN
  task automatic test_perf_counters();
    apply_reset();
    tick(); tick(); tick();
    stall = 1'b1; tick();
    stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h0; tick();
    redirect = 1'b0;
    checks++; if (fetch_cnt !== 32'd3 || bubble_cnt !== 32'd1) begin
      errors++; $display("FAIL perf_cnts got=%0d/%0d exp=3/1", fetch_cnt, bubble_cnt); end
  endtask
`endif

  task automatic test_random();
    logic [31:0] w;
    int bad;
    apply_reset();
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      if ($urandom_range(0, 19) == 0) w[31:26] = 6'h3F;
      mem[i] = w;
    end
    bad = 0;
    for (int n = 0; n < 600; n++) begin
      stall = ($urandom_range(0, 3) == 0);
      redirect = ($urandom_range(0, 7) == 0);
      redirect_pc = ($urandom_range(0, 2) == 0) ? $urandom : $urandom_range(0, 32'h7FF);
      model_edge();
      tick();
      checks++; if (cur_pc !== m_pc || im_addr !== m_pc[9:2]) begin
        errors++; if (bad++ < 10) $display("FAIL rnd_pc n=%0d got=%h a%h exp=%h", n, cur_pc, im_addr, m_pc); end
      checks++; if (halted !== m_halt || ifid_valid !== m_valid || ifid_instr !== m_instr) begin
        errors++; if (bad++ < 10) $display("FAIL rnd_ifid n=%0d got=h%b v%b %h exp=h%b v%b %h", n, halted, ifid_valid, ifid_instr, m_halt, m_valid, m_instr); end
      if (m_valid) begin
        checks++; if (ifid_pc !== m_ipc || ifid_pc4 !== m_ipc + 32'd4) begin
          errors++; if (bad++ < 10) $display("FAIL rnd_ifidpc n=%0d got=%h/%h exp=%h", n, ifid_pc, ifid_pc4, m_ipc); end
      end
`ifdef IF_PERF_CNT_EN
      checks++; if (fetch_cnt !== m_fc || bubble_cnt !== m_bc) begin
        errors++; if (bad++ < 10) $display("FAIL rnd_cnts n=%0d got=%0d/%0d exp=%0d/%0d", n, fetch_cnt, bubble_cnt, m_fc, m_bc); end
`endif
    end
    stall = 1'b0; redirect = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_over_stall();
    test_halt();
    test_wrap_and_async_reset();
`ifdef IF_PERF_CNT_EN
    test_perf_counters();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the pipelined CPU.
- Owns the program counter and drives the word address into the instruction memory.
- The instruction memory is a combinational read of 256 x 32-bit words. This block captures the returned word plus PC metadata into the IF/ID pipeline register for the decode stage.
- Handles hazard-unit stalls, EX-stage redirects (branch/jump flush) and the halt instruction.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0).
- IM_AW, 8, instruction-memory word-address width; IM_Addr = PC[IM_AW+1:2].
- HALT_OP, 6'b111111, opcode (Instr[31:26]) of the halt instruction.

Ports:
- CLK  in  1  single clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Stall  in  1  hazard unit: hold PC and IF/ID this cycle.
- Redirect  in  1  EX stage: taken branch/jump, load RedirectPC and flush IF/ID.
- RedirectPC  in  32  redirect target.
- IM_Addr  out  IM_AW  word address to instruction memory.
- IM_Instr  in  32  instruction word returned by memory in the same cycle.
- CurPC  out  32  current PC register value.
- IFID_Valid  out  1  IF/ID holds a real instruction (0 = bubble).
- IFID_Instr  out  32  latched instruction (32'h0 when bubble).
- IFID_PC  out  32  PC of latched instruction.
- IFID_PC4  out  32  IFID_PC + 4.
- Halted  out  1  fetch is in HALT state.

Behaviour:
- Reset (Reset=0, asynchronous, takes effect immediately):
  - PC=RESET_PC, state=RUN.
  - IFID_Valid=0; IFID_Instr, IFID_PC and IFID_PC4 all 0.
  - Halted=0.
- Deassertion is sampled at the next rising CLK. The first fetch occurs at the first edge with Reset=1.
- IM_Addr = PC[IM_AW+1:2], combinational from the PC register. IM_Instr is consumed in the same cycle (zero-latency memory).
- Fetch latency: an instruction at PC appears on IFID_* one edge after PC holds that value.
- PC arithmetic:
  - PC+4 is modulo 2^32.
  - IM_Addr wraps naturally at 2^IM_AW words (PC 0x3FC -> 0x400 gives IM_Addr 0xFF -> 0x00).
  - RedirectPC[1:0] is ignored and forced to 00.
- State RUN, per edge, in priority order:
  1. Redirect=1: PC<=RedirectPC&~3; IF/ID<=bubble. Redirect overrides Stall.
  2. Stall=1: PC and all IFID_* hold.
  3. Otherwise: PC<=PC+4; IFID_Valid<=1; IFID_Instr<=IM_Instr; IFID_PC<=PC; IFID_PC4<=PC+4.
  4. If case 3 applies and IM_Instr[31:26]==HALT_OP: the halt word is latched as a normal valid instruction, PC<=PC (not incremented), and state<=HALT.
- State HALT (Halted=1):
  - Redirect=1: PC<=RedirectPC&~3, IF/ID<=bubble, state<=RUN. This handles a halt fetched on a wrong path.
  - Stall=1: IF/ID holds, so the latched halt instruction is not lost.
  - Otherwise: IF/ID<=bubble every edge; PC holds.
- A halt word seen while Stall=1 or Redirect=1 does not change state.
- No other state exists. Reset from any state returns to RUN with PC=RESET_PC.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined: adds two outputs, each reset to 0 and wrapping at 2^32:
  - FetchCnt (32), +1 on every edge that latches a valid instruction.
  - BubbleCnt (32), +1 on every edge that loads a bubble due to Redirect or to HALT.
- Stalled edges increment neither counter.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, memory words 0..3 = 0x11111111..0x44444444, no stall/redirect, 4 edges -> IFID_Instr 0x11111111..0x44444444; IFID_PC 0,4,8,C; CurPC=0x10.
- Stall=1 for 2 edges while CurPC=8 -> CurPC stays 8, IFID_Instr stays 0x22222222/IFID_PC=4; release -> IFID_PC=8 next edge.
- Redirect=1, RedirectPC=0x47 with Stall=1 same cycle -> next edge CurPC=0x44, IFID_Valid=0, IFID_Instr=0; following edge IFID_PC=0x44.
- Halt word 0xFC000000 at PC=0x10 -> IFID_Instr=0xFC000000 valid once, Halted=1, CurPC stays 0x10, later edges IFID_Valid=0; Redirect to 0x20 -> Halted=0, fetch resumes at 0x20.
- PC=0x3FC sequential -> IM_Addr 0xFF then 0x00 with CurPC=0x400; Reset asserted mid-cycle -> all outputs 0 / CurPC=RESET_PC before next edge.
- With IF_PERF_CNT_EN: 3 fetches, 1 stall, 1 redirect -> FetchCnt=3, BubbleCnt=1.
